// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, snapshot classes
// and the key-code width calculation.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN_WAIT,
      DEBOUNCE,
      PRESSED
   } state_t;

   typedef enum logic [1:0] {
      EMPTY,
      SINGLE,
      MULTI
   } snap_class_t;

   function automatic int code_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the raw active-low row pins; resets to all ones
// so an idle (no key) keypad is what the scanner sees out of reset.
module keypad_row_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta_reg <= '1;
         sync_out <= '1;
      end else begin
         meta_reg <= async_in;
         sync_out <= meta_reg;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Keypad column scanner with whole-scan debouncing and one report per press.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int COLS           = 4,
   parameter int ROWS           = 4,
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int REPEAT_SCANS   = 20
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                scan_enable,
   input  logic [ROWS-1:0]                     row_sense,
   output logic [COLS-1:0]                     col_drive,
   output logic [code_width(ROWS*COLS)-1:0]    key_code,
   output logic                                key_valid,
   output logic                                key_held,
   output logic                                multi_key
);

   localparam int KEYS    = ROWS * COLS;
   localparam int CODE_W  = code_width(KEYS);
   localparam int COL_W   = code_width(COLS);
   localparam int DIV_W   = $clog2(SCAN_DIV);
   localparam int CNT_MAX = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_SCANS);

   logic [ROWS-1:0]   row_sync;
   logic              active_reg;
   logic [DIV_W-1:0]  div_reg;
   logic [COL_W-1:0]  col_reg;
   logic [KEYS-1:0]   snap_reg, snap_closed_reg, snap_next;
   logic              eval_reg;
   logic              dwell_end, scan_end;

   keypad_row_sync #(.WIDTH(ROWS)) u_row_sync (
      .clock    (clock),
      .reset_n  (reset_n),
      .async_in (row_sense),
      .sync_out (row_sync)
   );

   assign dwell_end = active_reg && (div_reg == DIV_W'(SCAN_DIV - 1));
   assign scan_end  = dwell_end && (col_reg == COL_W'(COLS - 1));

   genvar gi;
   generate
      for (gi = 0; gi < COLS; gi++) begin : g_col
         assign col_drive[gi] = !(active_reg && (col_reg == COL_W'(gi)));
      end
      // Bit row*COLS+col is set when that row reads low at the end of that column's dwell.
      for (gi = 0; gi < KEYS; gi++) begin : g_snap
         assign snap_next[gi] = snap_reg[gi] |
            (dwell_end && (col_reg == COL_W'(gi % COLS)) && !row_sync[gi / COLS]);
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         active_reg      <= 1'b0;
         div_reg         <= '0;
         col_reg         <= '0;
         snap_reg        <= '0;
         snap_closed_reg <= '0;
         eval_reg        <= 1'b0;
      end else if (!scan_enable) begin
         active_reg      <= 1'b0;
         div_reg         <= '0;
         col_reg         <= '0;
         snap_reg        <= '0;
         snap_closed_reg <= '0;
         eval_reg        <= 1'b0;
      end else if (!active_reg) begin
         active_reg <= 1'b1;
      end else begin
         eval_reg <= scan_end;
         snap_reg <= scan_end ? '0 : snap_next;
         if (scan_end)
            snap_closed_reg <= snap_next;
         if (dwell_end) begin
            div_reg <= '0;
            col_reg <= (col_reg == COL_W'(COLS - 1)) ? '0 : col_reg + COL_W'(1);
         end else begin
            div_reg <= div_reg + DIV_W'(1);
         end
      end
   end

   snap_class_t       snap_class;
   logic [CODE_W-1:0] hit_code;
   logic [1:0]        hits;

   always_comb begin
      hits     = 2'd0;
      hit_code = '0;
      for (int i = 0; i < KEYS; i++) begin
         if (snap_closed_reg[i]) begin
            if (hits != 2'd2)
               hits = hits + 2'd1;
            hit_code = CODE_W'(i);
         end
      end
      snap_class = (hits == 2'd0) ? EMPTY : (hits == 2'd1) ? SINGLE : MULTI;
   end

   state_t            state_reg, state_next;
   logic [CODE_W-1:0] cand_reg, cand_next, code_next;
   logic [CNT_W-1:0]  count_reg, count_next, count_inc;
   logic [CNT_W-1:0]  rel_reg, rel_next, rel_inc;
   logic              valid_next, held_next, multi_next, accept;
`ifdef KEYPAD_AUTOREPEAT_EN
   logic [CNT_W-1:0]  rep_reg, rep_next, rep_inc;
   assign rep_inc = (rep_reg == '1) ? rep_reg : rep_reg + CNT_W'(1);
`endif

   assign count_inc = (count_reg == '1) ? count_reg : count_reg + CNT_W'(1);
   assign rel_inc   = (rel_reg == '1) ? rel_reg : rel_reg + CNT_W'(1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= SCAN_WAIT;
         cand_reg  <= '0;
         count_reg <= '0;
         rel_reg   <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         multi_key <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_reg   <= '0;
`endif
      end else begin
         state_reg <= state_next;
         cand_reg  <= cand_next;
         count_reg <= count_next;
         rel_reg   <= rel_next;
         key_code  <= code_next;
         key_valid <= valid_next;
         key_held  <= held_next;
         multi_key <= multi_next;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_reg   <= rep_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      cand_next  = cand_reg;
      count_next = count_reg;
      rel_next   = rel_reg;
      code_next  = key_code;
      held_next  = key_held;
      multi_next = multi_key;
      valid_next = 1'b0;
      accept     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_next   = rep_reg;
`endif
      if (!scan_enable) begin
         state_next = SCAN_WAIT;
         count_next = '0;
         rel_next   = '0;
         held_next  = 1'b0;
         multi_next = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_next   = '0;
`endif
      end else if (eval_reg) begin
         multi_next = (snap_class == MULTI);
         case (state_reg)
            SCAN_WAIT: begin
               if (snap_class == SINGLE) begin
                  cand_next  = hit_code;
                  count_next = CNT_W'(1);
                  if (CNT_W'(1) >= DEB_CNT)
                     accept = 1'b1;
                  else
                     state_next = DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (snap_class == SINGLE && hit_code == cand_reg) begin
                  count_next = count_inc;
                  if (count_inc >= DEB_CNT)
                     accept = 1'b1;
               end else if (snap_class == SINGLE) begin
                  cand_next  = hit_code;
                  count_next = CNT_W'(1);
               end else begin
                  state_next = SCAN_WAIT;
                  count_next = '0;
               end
            end
            PRESSED: begin
               // Any key activity during the release run restarts it.
               if (snap_class == EMPTY) begin
                  rel_next = rel_inc;
                  if (rel_inc >= DEB_CNT) begin
                     held_next  = 1'b0;
                     state_next = SCAN_WAIT;
                     rel_next   = '0;
                  end
               end else begin
                  rel_next = '0;
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               if (snap_class == SINGLE && hit_code == key_code) begin
                  if (rep_inc >= CNT_W'(REPEAT_SCANS)) begin
                     valid_next = 1'b1;
                     rep_next   = '0;
                  end else begin
                     rep_next = rep_inc;
                  end
               end else begin
                  rep_next = '0;
               end
`endif
            end
            default: state_next = SCAN_WAIT;
         endcase
         if (accept) begin
            state_next = PRESSED;
            code_next  = cand_next;
            valid_next = 1'b1;
            held_next  = 1'b1;
            count_next = '0;
            rel_next   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_next   = '0;
`endif
         end
      end
   end

endmodule
